// File: rtl/vecmul_pkg.sv
// Shared types and elaboration-time helpers for the SIMD Wallace-tree multiplier.
package vecmul_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  localparam int NUM_STAGES = 3;

  // W Baugh-Wooley rows plus one row carrying the signed-mode correction constant.
  function automatic int lane_pp_rows(input int w);
    return w + 1;
  endfunction

  function automatic int csa_rows_out(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int wallace_levels(input int n);
    int r;
    int lvl;
    r   = n;
    lvl = 0;
    while (r > 2) begin
      r   = csa_rows_out(r);
      lvl = lvl + 1;
    end
    return lvl;
  endfunction

  function automatic int wallace_rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int k = 0; k < lvl; k++) begin
      r = csa_rows_out(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_lane_wallace.sv
// One multiplier lane: partial products -> S1, Wallace reduction -> S2, carry-propagate add -> S3.
module mul_lane_wallace
  import vecmul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s1_load_i,
  input  logic           s2_load_i,
  input  logic           s3_load_i,
  input  logic           signed_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] product_o
);

  localparam int PW   = 2 * W;
  localparam int R0   = lane_pp_rows(W);
  localparam int NLEV = wallace_levels(R0);

  localparam logic [PW-1:0] ONE      = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] BW_CONST = (ONE << W) | (ONE << (PW - 1));

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
    logic [PW-1:0] m;
    m = (x & y) | (x & z) | (y & z);
    return {m[PW-2:0], 1'b0};
  endfunction

  logic [PW-1:0] pp_d  [R0];
  logic [PW-1:0] pp_q  [R0];
  logic [PW-1:0] tree  [NLEV+1][R0];
  logic [PW-1:0] sum_q;
  logic [PW-1:0] carry_q;
  logic [PW-1:0] prod_d;
  logic [PW-1:0] prod_q;

  // Baugh-Wooley rows: in signed mode, cross terms with exactly one sign bit are inverted.
  always_comb begin
    for (int j = 0; j < W; j++) begin
      pp_d[j] = '0;
      for (int i = 0; i < W; i++) begin
        pp_d[j][i+j] = (a_i[i] & b_i[j]) ^ (signed_i & ((i == W - 1) != (j == W - 1)));
      end
    end
    pp_d[W] = signed_i ? BW_CONST : '0;
  end

  // S1 register: partial-product rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < R0; r++) pp_q[r] <= '0;
    end else if (s1_load_i) begin
      for (int r = 0; r < R0; r++) pp_q[r] <= pp_d[r];
    end
  end

  for (genvar r = 0; r < R0; r++) begin : g_lvl0
    assign tree[0][r] = pp_q[r];
  end

  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int RI = wallace_rows_at(R0, l);
    localparam int NT = RI / 3;
    localparam int RO = csa_rows_out(RI);
    for (genvar t = 0; t < NT; t++) begin : g_csa
      assign tree[l+1][2*t]   = csa_sum(tree[l][3*t], tree[l][3*t+1], tree[l][3*t+2]);
      assign tree[l+1][2*t+1] = csa_carry(tree[l][3*t], tree[l][3*t+1], tree[l][3*t+2]);
    end
    for (genvar r = 0; r < RI - 3 * NT; r++) begin : g_pass
      assign tree[l+1][2*NT+r] = tree[l][3*NT+r];
    end
    for (genvar r = RO; r < R0; r++) begin : g_zero
      assign tree[l+1][r] = '0;
    end
  end

  // S2 register: the two rows left by the tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else if (s2_load_i) begin
      sum_q   <= tree[NLEV][0];
      carry_q <= tree[NLEV][1];
    end
  end

  assign prod_d = sum_q + carry_q;

  // S3 register: final product, held whenever no new result is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (s3_load_i) begin
      prod_q <= prod_d;
    end
  end

  assign product_o = prod_q;

endmodule

// File: rtl/vecmul_wallace_pipe.sv
// SIMD W x W multiplier, 3-stage pipeline with valid/ready handshake and bubble collapsing.
module vecmul_wallace_pipe
  import vecmul_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_signed,
  output logic [LANES*2*W-1:0] product
);

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [NUM_STAGES-1:0] load_s;
  logic                  adv1_s;
  logic                  adv2_s;
  logic                  adv3_s;
  mode_e                 mode_q [NUM_STAGES];
  mode_e                 mode_d [NUM_STAGES];

  // A stage advances when empty or when its successor advances.
  always_comb begin
    adv3_s = !valid_q[2] || out_ready;
    adv2_s = !valid_q[1] || adv3_s;
    adv1_s = !valid_q[0] || adv2_s;

    load_s[0] = in_valid   && adv1_s;
    load_s[1] = valid_q[0] && adv2_s;
    load_s[2] = valid_q[1] && adv3_s;

    valid_d[0] = adv1_s ? in_valid   : valid_q[0];
    valid_d[1] = adv2_s ? valid_q[0] : valid_q[1];
    valid_d[2] = adv3_s ? valid_q[1] : valid_q[2];

    mode_d[0] = load_s[0] ? mode_e'(in_signed) : mode_q[0];
    mode_d[1] = load_s[1] ? mode_q[0]          : mode_q[1];
    mode_d[2] = load_s[2] ? mode_q[1]          : mode_q[2];
  end

  // Stage valid bits and the mode bit travelling with each stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) mode_q[k] <= MODE_UNSIGNED;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < NUM_STAGES; k++) mode_q[k] <= mode_d[k];
    end
  end

  assign in_ready   = adv1_s;
  assign out_valid  = valid_q[NUM_STAGES-1];
  assign out_signed = (mode_q[NUM_STAGES-1] == MODE_SIGNED);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mul_lane_wallace #(
      .W(W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .s1_load_i (load_s[0]),
      .s2_load_i (load_s[1]),
      .s3_load_i (load_s[2]),
      .signed_i  (in_signed),
      .a_i       (in_a[g*W +: W]),
      .b_i       (in_b[g*W +: W]),
      .product_o (product[g*2*W +: 2*W])
    );
  end

endmodule

// File: tb/tb_vecmul_wallace_pipe.sv
// Randomized and directed bench for vecmul_wallace_pipe, two configurations (4x8 and 8x12).
module tb_vecmul_wallace_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         cfg;
  logic         v_i, s_i, rdy_i;
  logic [191:0] a_i, b_i;

  logic         ir_a, ov_a, os_a;
  logic [63:0]  prod_a;
  logic         ir_b, ov_b, os_b;
  logic [191:0] prod_b;

  logic         cur_ir, cur_ov, cur_os;
  logic [191:0] cur_prod;

  vecmul_wallace_pipe #(.LANES(4), .W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(v_i & ~cfg), .in_ready(ir_a), .in_signed(s_i),
    .in_a(a_i[31:0]), .in_b(b_i[31:0]), .out_valid(ov_a), .out_ready(rdy_i),
    .out_signed(os_a), .product(prod_a)
  );

  vecmul_wallace_pipe #(.LANES(8), .W(12)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(v_i & cfg), .in_ready(ir_b), .in_signed(s_i),
    .in_a(a_i[95:0]), .in_b(b_i[95:0]), .out_valid(ov_b), .out_ready(rdy_i),
    .out_signed(os_b), .product(prod_b)
  );

  assign cur_ir   = cfg ? ir_b : ir_a;
  assign cur_ov   = cfg ? ov_b : ov_a;
  assign cur_os   = cfg ? os_b : os_a;
  assign cur_prod = cfg ? prod_b : {128'd0, prod_a};

  typedef struct packed {
    logic [191:0] p;
    logic         s;
  } exp_t;

  exp_t         q[$];
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           last_pop = 0;
  int           n_pop = 0;
  logic         stall_q = 1'b0;
  logic [191:0] held = '0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] rnd192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: per lane, interpret operands as integers and multiply, keep 2W bits.
  function automatic logic [191:0] ref_mul(input logic [191:0] a, input logic [191:0] b,
                                           input logic s, input int lanes, input int w);
    logic [191:0] r;
    longint av, bv, p, m, m2;
    r  = '0;
    m  = (longint'(1) << w) - longint'(1);
    m2 = (longint'(1) << (2 * w)) - longint'(1);
    for (int i = 0; i < lanes; i++) begin
      av = longint'(a >> (i * w)) & m;
      bv = longint'(b >> (i * w)) & m;
      if (s && (((av >> (w - 1)) & longint'(1)) != 0)) av = av - (longint'(1) << w);
      if (s && (((bv >> (w - 1)) & longint'(1)) != 0)) bv = bv - (longint'(1) << w);
      p = (av * bv) & m2;
      r = r | (192'(p) << (2 * w * i));
    end
    return r;
  endfunction

  // Call at a falling edge: drive inputs, sample handshakes, score outputs, wait one cycle.
  task automatic drive_cycle(input logic v, input logic [191:0] a, input logic [191:0] b,
                             input logic s, input logic rdy, input logic [191:0] e,
                             output logic acc);
    exp_t x;
    v_i = v; a_i = a; b_i = b; s_i = s; rdy_i = rdy;
    #1;
    acc = v && cur_ir;
    if (stall_q) chk("stall_hold", cur_prod, held);
    if (cur_ov && rdy) begin
      if (q.size() == 0) begin
        chk("no_output", {191'd0, cur_ov}, 192'd0);
      end else begin
        x = q.pop_front();
        chk("product", cur_prod, x.p);
        chk("out_signed", {191'd0, cur_os}, {191'd0, x.s});
        last_pop = cyc;
        n_pop++;
      end
    end
    if (acc) q.push_back('{p: e, s: s});
    stall_q = cur_ov && !rdy;
    held    = cur_prod;
    cyc++;
    @(negedge clk);
  endtask

  logic [191:0] ta [5];
  logic [191:0] tbv[5];
  logic         ts [5];
  logic         acc;
  int           k, c, t_acc, pop0, sent, lanes, w;
  logic [191:0] ea, eb;

  initial begin
    rst_n = 1'b0; cfg = 1'b0; v_i = 1'b0; s_i = 1'b0; rdy_i = 1'b1; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {191'd0, cur_ov}, 192'd0);
    chk("rst_product", cur_prod, 192'd0);
    chk("rst_out_signed", {191'd0, cur_os}, 192'd0);
    chk("rst_in_ready", {191'd0, cur_ir}, 192'd1);

    // Directed unsigned and signed vectors with latency measurement.
    for (int m = 0; m < 2; m++) begin
      ea = (m == 0) ? {160'd0, 32'hFF80_0100} : {160'd0, 32'h80FF_7F80};
      eb = (m == 0) ? {160'd0, 32'hFF02_FF37} : {160'd0, 32'h807F_7F01};
      t_acc = cyc;
      drive_cycle(1'b1, ea, eb, m[0],
                  1'b1, (m == 0) ? {128'd0, 64'hFE01_0100_00FF_0000}
                                 : {128'd0, 64'h4000_FF81_3F01_FF80}, acc);
      chk("dir_accept", {191'd0, acc}, 192'd1);
      c = 0;
      while (q.size() != 0 && c < 8) begin
        drive_cycle(1'b0, rnd192(), rnd192(), 1'b1, 1'b1, '0, acc);
        c++;
      end
      chk("dir_drained", q.size(), 0);
      chk("dir_latency", last_pop - t_acc, 3);
    end

    // Backpressure: five transactions against a stalled output.
    for (int i = 0; i < 5; i++) begin
      ta[i] = rnd192(); tbv[i] = rnd192(); ts[i] = 1'($urandom_range(1));
    end
    k = 0;
    for (int cc = 0; cc < 5; cc++) begin
      drive_cycle(1'b1, ta[k], tbv[k], ts[k], 1'b0, ref_mul(ta[k], tbv[k], ts[k], 4, 8), acc);
      if (cc >= 3) begin
        chk("in_ready_full", {191'd0, acc}, 192'd0);
        chk("frozen_first", cur_prod, q[0].p);
      end
      if (acc) k++;
    end
    chk("accepted_under_stall", k, 3);
    pop0 = n_pop;
    c = 0;
    while ((k < 5 || q.size() != 0) && c < 20) begin
      drive_cycle(k < 5, ta[k < 5 ? k : 0], tbv[k < 5 ? k : 0], ts[k < 5 ? k : 0], 1'b1,
                  ref_mul(ta[k < 5 ? k : 0], tbv[k < 5 ? k : 0], ts[k < 5 ? k : 0], 4, 8), acc);
      if (acc) k++;
      c++;
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_count", n_pop - pop0, 5);
    chk("drain_cycles", c, 5);

    // Alternating mode at full rate, all operands 0xFF.
    ea = {160'd0, 32'hFFFF_FFFF};
    c = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, ea, ea, i[0], 1'b1,
                  i[0] ? {128'd0, {4{16'h0001}}} : {128'd0, {4{16'hFE01}}}, acc);
      c++;
    end
    while (q.size() != 0 && c < 20) begin
      drive_cycle(1'b0, rnd192(), rnd192(), 1'b0, 1'b1, '0, acc);
      c++;
    end
    chk("alt_rate", c, 11);

    // Reset with two transactions in flight.
    drive_cycle(1'b1, rnd192(), rnd192(), 1'b0, 1'b0, '0, acc);
    drive_cycle(1'b1, rnd192(), rnd192(), 1'b1, 1'b0, '0, acc);
    drive_cycle(1'b0, rnd192(), rnd192(), 1'b0, 1'b0, '0, acc);
    chk("pre_reset_valid", {191'd0, cur_ov}, 192'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", {191'd0, cur_ov}, 192'd0);
    chk("reset_product", cur_prod, 192'd0);
    q.delete();
    stall_q = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, rnd192(), rnd192(), 1'b0, 1'b1, '0, acc);
      chk("post_reset_quiet", {191'd0, cur_ov}, 192'd0);
    end

    // Random regression on both configurations.
    for (int cf = 0; cf < 2; cf++) begin
      cfg   = cf[0];
      lanes = (cf == 0) ? 4 : 8;
      w     = (cf == 0) ? 8 : 12;
      sent  = 0;
      c     = 0;
      while ((sent < 10000 || q.size() != 0) && c < 45000) begin
        ea = rnd192();
        eb = rnd192();
        s_i = 1'($urandom_range(1));
        drive_cycle((sent < 10000) && ($urandom_range(3) != 0), ea, eb, s_i,
                    1'($urandom_range(1)), ref_mul(ea, eb, s_i, lanes, w), acc);
        if (acc) sent++;
        c++;
      end
      chk("rand_sent", sent, 10000);
      chk("rand_drained", q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vecmul_wallace_pipe.md
Name: vecmul_wallace_pipe

Overview:
Parametrised SIMD multiplier. It computes LANES independent W x W products per transaction, with the signed/unsigned mode selectable per transaction. It is a 3-stage pipeline: partial products, Wallace compression, then the final carry-propagate adder. It adds valid/ready backpressure with bubble collapsing, and it is the multiplier front end of the int8 vector-MAC datapath.

Parameters:
LANES, 4, number of independent multiplier lanes (1..16)
W, 8, operand width per lane in bits (4..16)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream transaction valid
in_ready  out  1  block can accept a transaction this cycle
in_signed  in  1  1 = lanes are two's complement, 0 = unsigned; sampled with in_valid
in_a  in  LANES*W  packed operands, lane i = in_a[i*W +: W]
in_b  in  LANES*W  packed operands, lane i = in_b[i*W +: W]
out_valid  out  1  product valid
out_ready  in  1  downstream accepts product
out_signed  out  1  mode bit travelling with the product
product  out  LANES*2W  packed results, lane i = product[i*2W +: 2W]

Behaviour:
- Reset (async assert, sync release): every stage valid = 0, out_valid = 0, product = 0, out_signed = 0, in_ready = 1 on the first cycle after release.
- Handshakes:
  - Input transfer when in_valid && in_ready at a rising edge.
  - Output transfer when out_valid && out_ready.
  - in_a, in_b and in_signed are don't-care while in_valid = 0.
- Pipeline: stages S1 (operand capture + partial products), S2 (Wallace reduction to two rows), S3 (CPA, drives product).
  - Each stage has a valid bit.
  - Stage k advances when it is empty or stage k+1 advances; S3 advances when !out_valid || out_ready.
  - in_ready = S1 advances (combinational from out_ready and the valid bits; no path from in_valid).
- Latency: with no stall, a transfer at edge T gives out_valid = 1 and a stable product after edge T+2. Throughput is 1 transaction/cycle.
- Stall: while out_valid && !out_ready, product and out_signed hold. Bubbles collapse, so at most 3 transactions are in flight and in_ready drops only when all three stages are full and out_ready = 0.
- Arithmetic per lane:
  - Unsigned: product = a*b, zero-extended to 2W.
  - Signed: product = two's-complement a*b in 2W bits, using Baugh-Wooley partial products.
  - The mode bit is carried through every stage with its data and never re-sampled.
  - The result is exact for all 2^(2W) operand pairs in both modes.
- Corner cases:
  - Signed (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), which is exact with no overflow.
  - Unsigned (2^W-1)^2 = 2^(2W) - 2^(W+1) + 1.
- Lanes are fully independent; no carry crosses a lane boundary.
- Simultaneous output transfer and input transfer in the same cycle while full: both occur, with no bubble inserted.
- Reset mid-operation: all in-flight transactions are discarded, nothing is emitted afterwards, and out_valid falls asynchronously with rst_n.
- No X propagation onto product when out_valid = 0: product holds its last value, or 0 after reset.

Decomposition:
- Package vecmul_pkg:
  - typedef mode_e {MODE_UNSIGNED=0, MODE_SIGNED=1}
  - function lane_pp_rows(W) returning the partial-product row count
  - localparam NUM_STAGES = 3
- Sub-module mul_lane_wallace holds one lane's combinational partial-product, Wallace-tree and CPA logic, split at two register boundaries exposed by ports. It is instantiated LANES times by generate.
- The top holds the valid/ready control and stage valid bits only.

Test Plan:
- Unsigned, W=8, LANES=4: a={FF,80,01,00}, b={FF,02,FF,37}, out_ready=1 -> exactly 3 edges later product={FE01,0100,00FF,0000}, out_signed=0.
- Signed, same lane layout: a={80,FF,7F,80}, b={80,7F,7F,01} -> product={4000,FF81,3F01,FF80}, out_signed=1.
- Backpressure: out_ready=0, drive 5 back-to-back transactions.
  - Expect 3 accepted, with in_ready=0 from the 4th.
  - product is frozen on the first result.
  - Releasing out_ready drains all results in order, one per cycle, with none lost or duplicated.
- Alternating in_signed every cycle with a=b=0xFF in all lanes -> outputs alternate FE01 / 0001 at full rate.
- Assert rst_n=0 with 2 transactions in flight -> out_valid=0 immediately, product=0, no output after release.
- Random regression: 10,000 transactions, random mode, random out_ready (50%), LANES=4/W=8 and LANES=8/W=12 -> all results match the reference model, in order.
